// File: rtl/bw_clk_gclk_pkg.sv
// Purpose: shared types and constants for the gated global-clock enable sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bw_clk_gclk_pkg;

    // Sequencer FSM: IDLE may grant one enable change; WAIT holds off further changes.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Width of the settle-interval counter and of dly_cfg.
    localparam int DLY_W = 4;

    // Default number of sequenced clock domains.
    localparam int NUM_DOM_DEF = 4;

    // Pointer width for a given domain count (at least one bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bw_clk_gclk_rr_arb.sv
// Purpose: round-robin pick of one pending domain, search starting at ptr and wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the grant.
module bw_clk_gclk_rr_arb
    import bw_clk_gclk_pkg::*;
#(
    parameter int N  = NUM_DOM_DEF,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    // Two copies back to back let the wrapped search be a plain forward scan.
    logic [2*N-1:0] pend2;

    assign pend2 = {pending, pending};

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend2[int'(ptr) + i]) begin
                valid = 1'b1;
                grant = PW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/bw_clk_gclk_en_seq.sv
// Purpose: sequence per-domain clock enables one at a time with a settle gap (optional freeze via BW_CLK_GCLK_FREEZE_EN).
// Latency: a request seen in IDLE changes clk_en on the next edge; consecutive changes are dly_cfg+2 cycles apart.
// Backpressure: requests arriving while busy are held as pending until the FSM returns to IDLE; freeze blocks new grants.
module bw_clk_gclk_en_seq
    import bw_clk_gclk_pkg::*;
#(
    parameter int NUM_DOM = NUM_DOM_DEF
) (
    input  logic               rclk,
    input  logic               rst,
`ifdef BW_CLK_GCLK_FREEZE_EN
    input  logic               freeze,
`endif
    input  logic [NUM_DOM-1:0] en_req,
    input  logic [DLY_W-1:0]   dly_cfg,
    output logic [NUM_DOM-1:0] clk_en,
    output logic               busy,
    output logic [NUM_DOM-1:0] chg_pls
);

    localparam int PW = ptr_w(NUM_DOM);

    state_t             state;
    logic [DLY_W-1:0]   cnt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [NUM_DOM-1:0] pending;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               frz;

`ifdef BW_CLK_GCLK_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    // A domain is pending whenever its request differs from its live enable;
    // a request that reverts before service simply stops being pending.
    assign pending = en_req ^ clk_en;

    bw_clk_gclk_rr_arb #(
        .N  (NUM_DOM),
        .PW (PW)
    ) u_arb (
        .pending (pending),
        .ptr     (ptr),
        .grant   (gnt_idx),
        .valid   (gnt_vld)
    );

    // Pointer moves to the domain after the one just served, wrapping.
    always_comb begin
        ptr_nxt = gnt_idx + 1'b1;
        if (gnt_idx == PW'(NUM_DOM - 1)) begin
            ptr_nxt = '0;
        end
    end

    // Sequencer FSM: one enable change per grant, then hold for dly_cfg+1 WAIT cycles.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            clk_en  <= '0;
            chg_pls <= '0;
            busy    <= 1'b0;
        end else begin
            chg_pls <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld && !frz) begin
                        clk_en[gnt_idx]  <= en_req[gnt_idx];
                        chg_pls[gnt_idx] <= 1'b1;
                        cnt              <= dly_cfg;
                        ptr              <= ptr_nxt;
                        state            <= WAIT;
                        busy             <= 1'b1;
                    end
                end
                WAIT: begin
                    // The edge that sees cnt==0 only returns to IDLE; no grant here.
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // At most one enable may flip per edge.
    a_onehot_pls : assert property (@(posedge rclk) disable iff (rst) $onehot0(chg_pls));

    // The pulse marks exactly the enable bit that flipped on the previous edge.
    a_pls_match : assert property (@(posedge rclk) disable iff (rst)
        !$past(rst) |-> ((clk_en ^ $past(clk_en)) == chg_pls));

endmodule
